// File: rtl/cpu_pkg.sv
// Types and constants shared across the CPU front end.
// The fetch stage and its queue import this package.
package cpu_pkg;

  localparam int INST_BYTES = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: code memory port, redirect input and decode handshake.
// The master modport is the fetch side; the slave modport is the memory/decode side.
interface fetch_stage_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output out_fault
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  out_fault
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry shift FIFO of fetch entries; slot0 is always the head.
// Flush beats push and pop; simultaneous push/pop while full keeps the count at 2.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign head    = slot0;

  // NOTE: the storage slots are reset because the head drives module outputs that must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every slot update sees pre-edge values.
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALT control and fetch fault check.
// Fetched words are queued in fetch_queue and handed to decode from its head register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned CODE_SIZE = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  fetch_state_t state;
  fetch_state_t next_state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic [32:0]  last_byte;
  logic         fault_now;
  logic         push;
  logic         pop;
  logic [1:0]   count;
  fetch_entry_t entry;
  fetch_entry_t head;

  // 33-bit sum so a PC near the top of the address space cannot wrap back in range.
  assign last_byte = {1'b0, pc} + 33'd3;
  assign fault_now = (pc[1:0] != 2'b00) || (last_byte >= 33'(CODE_SIZE));

  assign pop = (count != 2'd0) && bus.out_ready;

  assign entry.pc    = pc;
  assign entry.inst  = fault_now ? 32'h0 : bus.imem_inst;
  assign entry.fault = fault_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end

  // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    push       = 1'b0;
    if (bus.redirect_valid) begin
      next_state = RUN;
      next_pc    = bus.redirect_pc;
    end else if ((state == RUN) && ((count != 2'd2) || pop)) begin
      push = 1'b1;
      if (fault_now) next_state = HALT;
      else           next_pc    = pc + 32'(INST_BYTES);
    end
  end

  fetch_queue u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (entry),
    .head  (head),
    .count (count)
  );

  assign bus.imem_addr = pc;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_inst  = head.inst;
  assign bus.out_pc    = head.pc;
  assign bus.out_fault = head.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a combinational code memory model.
// Each task drives one scenario and checks the decode-side outputs inline.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fetch_stage_if bus ();

  fetch_stage #(
    .CODE_SIZE (1024),
    .RESET_PC  (32'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words 0..3 are 11,22,33,44; word i above that is 0x1000_0000+i.
  // Misaligned or out-of-range addresses return a poison value the DUT must not forward.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr[1:0] != 2'b00 || addr >= 32'd1024) return 32'hDEAD_BEEF;
    case (addr[9:2])
      8'd0:    return 32'd11;
      8'd1:    return 32'd22;
      8'd2:    return 32'd33;
      8'd3:    return 32'd44;
      default: return 32'h1000_0000 + {24'h0, addr[9:2]};
    endcase
  endfunction

  assign bus.imem_inst = mem_word(bus.imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst_n              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    @(negedge clk);
    bus.out_ready = ready;
    rst_n         = 1'b1;
  endtask

  task automatic test_reset();
    rst_n              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    #12;
    n_tests++;
    if ({bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst, bus.imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b f=%0b pc=%h inst=%h addr=%h, want all zero",
               bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst, bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_inst [4];
    exp_inst = '{32'd11, 32'd22, 32'd33, 32'd44};
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if ({bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst, bus.imem_addr} !==
          {1'b1, 1'b0, 32'(4 * i), exp_inst[i], 32'(4 * i + 4)}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%0b f=%0b pc=%h inst=%h addr=%h, want v=1 f=0 pc=%h inst=%h addr=%h",
                 i, bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst, bus.imem_addr,
                 32'(4 * i), exp_inst[i], 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc   [4];
    logic [31:0] exp_inst [4];
    exp_pc   = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_inst = '{32'd11, 32'd22, 32'd33, 32'd44};
    do_reset(1'b0);
    repeat (5) step();
    n_tests++;
    if ({bus.out_valid, bus.out_pc, bus.imem_addr} !== {1'b1, 32'h0, 32'h8}) begin
      n_fail++;
      $display("FAIL backpressure_stall: got v=%0b pc=%h addr=%h, want v=1 pc=0 addr=8",
               bus.out_valid, bus.out_pc, bus.imem_addr);
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      n_tests++;
      if ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, exp_pc[i], exp_inst[i]}) begin
        n_fail++;
        $display("FAIL backpressure_drain[%0d]: got v=%0b pc=%h inst=%h, want v=1 pc=%h inst=%h",
                 i, bus.out_valid, bus.out_pc, bus.out_inst, exp_pc[i], exp_inst[i]);
      end
    end
  endtask

  task automatic test_redirect_flush();
    do_reset(1'b0);
    repeat (3) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    bus.out_ready      = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    n_tests++;
    if ({bus.out_valid, bus.imem_addr} !== {1'b0, 32'h40}) begin
      n_fail++;
      $display("FAIL redirect_flush: got v=%0b addr=%h, want v=0 addr=40", bus.out_valid, bus.imem_addr);
    end
    step();
    n_tests++;
    if ({bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst} !== {1'b1, 1'b0, 32'h40, 32'h1000_0010}) begin
      n_fail++;
      $display("FAIL redirect_target: got v=%0b f=%0b pc=%h inst=%h, want v=1 f=0 pc=40 inst=10000010",
               bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst);
    end
  endtask

  task automatic test_fault_boundary();
    do_reset(1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3F8;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
    n_tests++;
    if ({bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst} !== {1'b1, 1'b0, 32'h3FC, 32'h1000_00FF}) begin
      n_fail++;
      $display("FAIL last_word: got v=%0b f=%0b pc=%h inst=%h, want v=1 f=0 pc=3fc inst=100000ff",
               bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst);
    end
    step();
    n_tests++;
    if ({bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst} !== {1'b1, 1'b1, 32'h400, 32'h0}) begin
      n_fail++;
      $display("FAIL oob_fault: got v=%0b f=%0b pc=%h inst=%h, want v=1 f=1 pc=400 inst=0",
               bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if ({bus.out_valid, bus.imem_addr} !== {1'b0, 32'h400}) begin
        n_fail++;
        $display("FAIL halt_idle[%0d]: got v=%0b addr=%h, want v=0 addr=400", i, bus.out_valid, bus.imem_addr);
      end
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    step();
    bus.redirect_valid = 1'b0;
    step();
    n_tests++;
    if ({bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst} !== {1'b1, 1'b0, 32'h10, 32'h1000_0004}) begin
      n_fail++;
      $display("FAIL halt_resume: got v=%0b f=%0b pc=%h inst=%h, want v=1 f=0 pc=10 inst=10000004",
               bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst);
    end
  endtask

  task automatic test_bad_redirect();
    logic [31:0] targets [2];
    targets = '{32'h6, 32'hFFFF_FFFE};
    do_reset(1'b1);
    for (int i = 0; i < 2; i++) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = targets[i];
      step();
      bus.redirect_valid = 1'b0;
      step();
      n_tests++;
      if ({bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst} !== {1'b1, 1'b1, targets[i], 32'h0}) begin
        n_fail++;
        $display("FAIL bad_target[%0d]: got v=%0b f=%0b pc=%h inst=%h, want v=1 f=1 pc=%h inst=0",
                 i, bus.out_valid, bus.out_fault, bus.out_pc, bus.out_inst, targets[i]);
      end
      step();
      n_tests++;
      if ({bus.out_valid, bus.imem_addr} !== {1'b0, targets[i]}) begin
        n_fail++;
        $display("FAIL bad_target_halt[%0d]: got v=%0b addr=%h, want v=0 addr=%h",
                 i, bus.out_valid, bus.imem_addr, targets[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.out_valid, bus.imem_addr} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%0b addr=%h, want v=0 addr=0", bus.out_valid, bus.imem_addr);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    step();
    n_tests++;
    if ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, 32'h0, 32'd11}) begin
      n_fail++;
      $display("FAIL restart: got v=%0b pc=%h inst=%h, want v=1 pc=0 inst=11",
               bus.out_valid, bus.out_pc, bus.out_inst);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_fault_boundary();
    test_bad_redirect();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
